uart_rx_fifo_writer: RTL

UART receive front end for the write-clock domain of the receive async FIFO. It oversamples the asynchronous serial line, assembles frames, checks framing and optional parity, and drives the FIFO write side (`winc`/`wdata`), honouring `wfull`. Only good frames are written. Frames that arrive while the FIFO is full are dropped and flagged as overruns.

---
 rtl/uart_pkg.sv | 32 +++
 rtl/uart_baud_tick.sv | 40 ++++
 rtl/uart_rx_fifo_writer.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared UART definitions: receive FSM state encoding,
//            oversampling constants and the parity helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Receive FSM states. WAIT_IDLE parks the receiver after a framing
    // error until the line returns high, so a break is reported only once.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_IDLE = 3'd5
    } uart_rx_state_t;

    localparam int OVERSAMPLE = 16;
    localparam int MID_SAMPLE = 7;

    // Expected parity bit for a data word of up to 9 bits. Narrower words
    // are zero-extended by the caller; zeros do not change the XOR.
    function automatic logic parity_calc(input logic [8:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`default_nettype none
// ============================================================================
// Module   : uart_baud_tick
// Purpose  : Oversample tick generator. Counts 0..BAUD_DIV-1 and pulses
//            tick for one cycle at BAUD_DIV-1. clr holds the counter at 0
//            so the first tick lands a fixed distance after its release.
// Ports    : clk  in  - clock
//            rst  in  - asynchronous active-high reset
//            clr  in  - synchronous counter clear, suppresses tick
//            tick out - one-cycle oversample strobe
// Revision : 1.0 - initial release
// ============================================================================
module uart_baud_tick #(
    parameter int BAUD_DIV = 27
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int               CW   = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CW-1:0]    LAST = CW'(BAUD_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST) && !clr;

endmodule
`default_nettype wire

// File: rtl/uart_rx_fifo_writer.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo_writer
// Purpose  : UART receiver feeding the write side of the RX async FIFO.
//            16x oversampling, framing and optional parity checking; only
//            good frames are written, frames arriving while the FIFO is
//            full are dropped and flagged as overruns.
// Ports    : wclk       in  - write-domain clock
//            wrst       in  - asynchronous active-high reset
//            rx_i       in  - asynchronous serial line (idles high)
//            wfull      in  - FIFO full flag (wclk domain)
//            winc       out - FIFO write strobe, one cycle
//            wdata      out - received word, valid with winc, held otherwise
//            frame_err  out - one-cycle pulse, stop bit sampled low
//            parity_err out - one-cycle pulse, parity mismatch
//            overrun    out - one-cycle pulse, good frame dropped (wfull)
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_fifo_writer
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int BAUD_DIV   = 27,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic                 wclk,
    input  logic                 wrst,
    input  logic                 rx_i,
    input  logic                 wfull,
    output logic                 winc,
    output logic [DATA_BITS-1:0] wdata,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun
);

    localparam int               BW          = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [BW-1:0]    LAST_BIT    = BW'(DATA_BITS - 1);
    localparam logic [3:0]       SAMPLE_LAST = 4'(OVERSAMPLE - 1);
    localparam logic [3:0]       SAMPLE_MID  = 4'(MID_SAMPLE);
    localparam logic             ODD         = (PARITY_ODD != 0);

    logic                 rx_meta;
    logic                 rx_s;
    logic                 tick;
    logic                 tick_clr;
    uart_rx_state_t       state;
    logic [3:0]           sample_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 parity_bit;

    // Two-flop synchronizer; reset to the idle (high) line level so a
    // reset release never looks like a start edge.
    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx_i;
            rx_s    <= rx_meta;
        end
    end

    // Holding the tick counter in IDLE makes the start-bit mid-sample land
    // exactly 8 ticks after the FSM leaves IDLE.
    assign tick_clr = (state == IDLE);

    uart_baud_tick #(
        .BAUD_DIV (BAUD_DIV)
    ) u_baud_tick (
        .clk  (wclk),
        .rst  (wrst),
        .clr  (tick_clr),
        .tick (tick)
    );

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            state      <= IDLE;
            sample_cnt <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            parity_bit <= 1'b0;
            winc       <= 1'b0;
            wdata      <= '0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            winc       <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;

            if (tick) begin
                sample_cnt <= sample_cnt + 1'b1;
            end

            case (state)
                IDLE: begin
                    sample_cnt <= '0;
                    bit_cnt    <= '0;
                    if (!rx_s) begin
                        state <= START;
                    end
                end

                START: begin
                    if (tick && sample_cnt == SAMPLE_MID) begin
                        if (rx_s) begin
                            state <= IDLE;          // glitch shorter than half a bit
                        end else begin
                            sample_cnt <= '0;       // re-centre: next 15 wraps at mid-bit
                            state      <= DATA;
                        end
                    end
                end

                DATA: begin
                    if (tick && sample_cnt == SAMPLE_LAST) begin
                        shreg <= {rx_s, shreg[DATA_BITS-1:1]};
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt <= '0;
                            state   <= (PARITY_EN != 0) ? PARITY : STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end

                PARITY: begin
                    if (tick && sample_cnt == SAMPLE_LAST) begin
                        parity_bit <= rx_s;
                        state      <= STOP;
                    end
                end

                STOP: begin
                    if (tick && sample_cnt == SAMPLE_LAST) begin
                        if (!rx_s) begin
                            frame_err <= 1'b1;
                            state     <= WAIT_IDLE;
                        end else if ((PARITY_EN != 0) &&
                                     (parity_bit != parity_calc(9'(shreg), ODD))) begin
                            parity_err <= 1'b1;
                            state      <= IDLE;
                        end else if (wfull) begin
                            overrun <= 1'b1;
                            state   <= IDLE;
                        end else begin
                            winc  <= 1'b1;
                            wdata <= shreg;
                            state <= IDLE;
                        end
                    end
                end

                WAIT_IDLE: begin
                    if (rx_s) begin
                        state <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
